// File: rtl/fc_ifm_feeder.sv
// Streams IFM_SIZE words from a source memory with one-cycle read latency
// to a ready/valid consumer through a 4-entry skid FIFO.
module fc_ifm_feeder #(
   parameter int IFM_SIZE   = 9162,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk1,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  valid_ifm,
   output logic [DATA_WIDTH-1:0] ifm_data,
   input  logic                  ifm_ready,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           counter_sent
);

   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = 2;
   localparam int CNT_W      = 3;
   localparam int IDX_W      = $clog2(IFM_SIZE + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [IDX_W-1:0]        rd_idx_q;
   logic                    inflight_q;
   logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]        count_q;
   logic [CNT_W-1:0]        count_d;
   logic [31:0]             sent_q;
   logic                    busy_q;
   logic                    done_q;

   logic rd_en;
   logic fifo_wr;
   logic xfer;
   logic last_rd;
   logic last_xfer;

   // A read is only issued if the returning word is guaranteed a FIFO slot.
   assign rd_en     = (state_q == FETCH) && (rd_idx_q < IDX_W'(IFM_SIZE))
                      && ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
   assign fifo_wr   = inflight_q;
   assign valid_ifm = (count_q != '0);
   assign xfer      = valid_ifm && ifm_ready;
   assign last_rd   = rd_en && (rd_idx_q == IDX_W'(IFM_SIZE - 1));
   assign last_xfer = xfer && (sent_q == 32'(IFM_SIZE - 1));

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (fifo_wr && !xfer) begin
         count_d = count_q + CNT_W'(1);
      end else if (!fifo_wr && xfer) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: FIFO storage has no reset; the count gates validity and ifm_data is masked when empty.
   always_ff @(posedge clk1) begin
      if (fifo_wr) begin
         fifo_q[wr_ptr_q] <= mem_rd_data;
      end
   end

   // NOTE: non-blocking assignments only; a later assignment in the case overrides the per-cycle updates above it.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         rd_idx_q   <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         sent_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         inflight_q <= rd_en;
         count_q    <= count_d;
         done_q     <= 1'b0;
         if (rd_en) begin
            rd_idx_q <= rd_idx_q + IDX_W'(1);
         end
         if (fifo_wr) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (xfer) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            sent_q   <= sent_q + 32'd1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= FETCH;
                  base_q     <= base_addr;
                  rd_idx_q   <= '0;
                  inflight_q <= 1'b0;
                  wr_ptr_q   <= '0;
                  rd_ptr_q   <= '0;
                  count_q    <= '0;
                  sent_q     <= '0;
                  busy_q     <= 1'b1;
               end
            end
            FETCH: begin
               if (last_rd) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_xfer) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_rd_en    = rd_en;
   assign mem_addr     = base_q + ADDR_WIDTH'(rd_idx_q);
   assign ifm_data     = valid_ifm ? fifo_q[rd_ptr_q] : '0;
   assign busy         = busy_q;
   assign done         = done_q;
   assign counter_sent = sent_q;

endmodule

// File: tb/tb_fc_ifm_feeder.sv
// Bench for fc_ifm_feeder with IFM_SIZE=8 and a memory returning addr+0x100;
// stream scenarios come from a vector table and are checked against a word scoreboard.
module tb_fc_ifm_feeder;

   localparam int IFM_SIZE = 8;

   logic        clk1;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic        valid_ifm;
   logic [31:0] ifm_data;
   logic        ifm_ready;
   logic        busy;
   logic        done;
   logic [31:0] counter_sent;

   fc_ifm_feeder #(
      .IFM_SIZE  (IFM_SIZE),
      .DATA_WIDTH(32),
      .ADDR_WIDTH(16)
   ) dut (
      .clk1        (clk1),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .valid_ifm   (valid_ifm),
      .ifm_data    (ifm_data),
      .ifm_ready   (ifm_ready),
      .busy        (busy),
      .done        (done),
      .counter_sent(counter_sent)
   );

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   // Source memory: data valid one cycle after the strobe, junk otherwise.
   always @(posedge clk1) begin
      if (mem_rd_en) mem_rd_data <= 32'(mem_addr) + 32'h100;
      else           mem_rd_data <= 32'hDEAD_BEEF;
   end

   typedef struct {
      logic [15:0] base;
      int          mode;         // 0: ready high, 1: ready low in cycles 4..9, 2: ready on odd cycles
      int          restart_cyc;  // extra start pulse with another base, -1 for none
      int          exp_done;
      bit          chain;        // next stream starts in the first cycle after done
      bit          pre_rst;      // abort a stream with reset before this one
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          carry_sent = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         1:       return !(c >= 4 && c <= 9);
         2:       return c[0];
         default: return 1'b1;
      endcase
   endfunction

   task automatic mid_reset();
      for (int c = 0; c < 9; c++) begin
         @(posedge clk1); #1;
         start     = (c == 0);
         base_addr = 16'h0000;
         ifm_ready = 1'b1;
         rst       = (c == 6);
         @(negedge clk1);
         if (c >= 7) begin
            check("rst_valid", valid_ifm, 0);
            check("rst_data", ifm_data, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rd_en", mem_rd_en, 0);
            check("rst_counter", counter_sent, 0);
         end
      end
      carry_sent = 0;
   endtask

   task automatic run_vec(input vec_t v);
      int          nreads = 0;
      int          nxfer = 0;
      int          last_xfer_cyc = -10;
      int          done_cyc = -1;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      logic [15:0] a;
      logic [31:0] exp_w;
      for (int i = 0; i < IFM_SIZE; i++) begin
         a = v.base + 16'(i);
         exp_q.push_back(32'(a) + 32'h100);
      end
      for (int c = 0; c < 80 && done_cyc < 0; c++) begin
         @(posedge clk1); #1;
         start     = (c == 0) || (c == v.restart_cyc);
         base_addr = (c == 0) ? v.base : (v.base ^ 16'h0F00);
         ifm_ready = ready_for(v.mode, c);
         @(negedge clk1);
         check("counter_sent", counter_sent, (c == 0) ? carry_sent : nxfer);
         if (c == 0) begin
            check("idle_busy", busy, 0);
            check("idle_valid", valid_ifm, 0);
            check("idle_rd_en", mem_rd_en, 0);
            check("idle_done", done, 0);
         end
         if (c == 1) check("lat_rd_en", mem_rd_en, 1);
         if (c == 3) check("lat_valid", valid_ifm, 1);
         if (mem_rd_en) begin
            a = v.base + 16'(nreads);
            check("rd_credit", (nreads - nxfer) < 4, 1);
            check("rd_limit", nreads < IFM_SIZE, 1);
            check("rd_addr", mem_addr, a);
            nreads++;
         end
         if (prev_stall) begin
            check("stall_valid", valid_ifm, 1);
            check("stall_data", ifm_data, prev_data);
         end
         prev_stall = valid_ifm && !ifm_ready;
         prev_data  = ifm_data;
         if (valid_ifm && ifm_ready) begin
            check("xfer_count", nxfer < IFM_SIZE, 1);
            if (exp_q.size() > 0) begin
               exp_w = exp_q.pop_front();
               check("ifm_data", ifm_data, exp_w);
            end
            nxfer++;
            last_xfer_cyc = c;
         end
         if (done) begin
            done_cyc = c;
            check("done_cycle", c, v.exp_done);
            check("done_after_last", last_xfer_cyc, c - 1);
            check("done_busy", busy, 0);
         end else if (c >= 1) begin
            check("busy", busy, 1);
         end
      end
      check("done_seen", done_cyc >= 0, 1);
      check("sb_empty", exp_q.size(), 0);
      exp_q.delete();
      carry_sent = IFM_SIZE;
      if (!v.chain) begin
         for (int t = 0; t < 2; t++) begin
            @(posedge clk1); #1;
            start     = 1'b0;
            ifm_ready = 1'b1;
            @(negedge clk1);
            check("post_done", done, 0);
            check("post_busy", busy, 0);
            check("post_valid", valid_ifm, 0);
            check("post_rd_en", mem_rd_en, 0);
            check("hold_counter", counter_sent, IFM_SIZE);
         end
      end
   endtask

   initial begin
      vec_t vecs [7];
      vecs[0] = '{16'h0000, 0, -1, 11, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 1, -1, 17, 1'b0, 1'b0};
      vecs[2] = '{16'h0020, 2, -1, 18, 1'b0, 1'b0};
      vecs[3] = '{16'h0040, 0,  5, 11, 1'b0, 1'b0};
      vecs[4] = '{16'hFFFC, 0, -1, 11, 1'b0, 1'b1};
      vecs[5] = '{16'h0010, 0, 11, 11, 1'b1, 1'b0};
      vecs[6] = '{16'h0030, 1, -1, 17, 1'b0, 1'b0};

      rst       = 1'b1;
      start     = 1'b0;
      base_addr = 16'h1234;
      ifm_ready = 1'b0;
      repeat (2) @(posedge clk1);
      @(negedge clk1);
      check("reset_rd_en", mem_rd_en, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_valid", valid_ifm, 0);
      check("reset_data", ifm_data, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_counter", counter_sent, 0);
      @(posedge clk1); #1;
      rst = 1'b0;
      @(negedge clk1);
      check("idle_after_reset_valid", valid_ifm, 0);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].pre_rst) mid_reset();
         run_vec(vecs[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
